// File: rtl/add_seq_pkg.sv
// Shared constants and types for the multi-cycle wide adder.
package add_seq_pkg;

  localparam int unsigned W         = 32;
  localparam int unsigned WORDS_DEF = 4;
  localparam int unsigned IDX_W     = (WORDS_DEF > 1) ? $clog2(WORDS_DEF) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  function automatic int unsigned idx_width(input int unsigned words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/wide_add_seq_if.sv
// Request/response bundle for wide_add_seq.
interface wide_add_seq_if #(
  parameter int unsigned WORDS = add_seq_pkg::WORDS_DEF,
  parameter int unsigned W     = add_seq_pkg::W
);

  logic                 in_valid;
  logic                 in_ready;
  logic [W*WORDS-1:0]   in_a;
  logic [W*WORDS-1:0]   in_b;
  logic                 in_sub;
  logic                 in_cin;
  logic                 out_valid;
  logic                 out_ready;
  logic [W*WORDS-1:0]   out_sum;
  logic                 out_cout;
  logic                 out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/skl_32_cskip_8.sv
// 32-bit carry-skip adder built from 8-bit Sklansky prefix blocks.
module skl_32_cskip_8 import add_seq_pkg::*; (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int unsigned BLK  = 8;
  localparam int unsigned NBLK = W / BLK;

  // Returns {group propagate, group generate} for every prefix [i:0] of the block.
  function automatic logic [2*BLK-1:0] prefix(input logic [BLK-1:0] g, input logic [BLK-1:0] p);
    logic [BLK-1:0] gc, pc, gn, pn;
    int j;
    gc = g;
    pc = p;
    for (int s = 0; s < $clog2(BLK); s++) begin
      gn = gc;
      pn = pc;
      for (int i = 0; i < BLK; i++) begin
        if (((i >> s) & 1) == 1) begin
          j     = ((i >> s) << s) - 1;
          gn[i] = gc[i] | (pc[i] & gc[j]);
          pn[i] = pc[i] & pc[j];
        end
      end
      gc = gn;
      pc = pn;
    end
    return {pc, gc};
  endfunction

  always_comb begin
    logic [BLK-1:0] g, p, gg, pp;
    logic           c;
    sum = '0;
    c   = cin;
    for (int k = 0; k < NBLK; k++) begin
      g        = a[k*BLK +: BLK] & b[k*BLK +: BLK];
      p        = a[k*BLK +: BLK] ^ b[k*BLK +: BLK];
      {pp, gg} = prefix(g, p);
      sum[k*BLK +: BLK] = p ^ {gg[BLK-2:0] | (pp[BLK-2:0] & {(BLK-1){c}}), c};
      // A fully propagating block passes its carry-in straight through.
      c = pp[BLK-1] ? c : gg[BLK-1];
    end
    cout = c;
  end

endmodule

// File: rtl/wide_add_seq.sv
// Wide add/subtract computed one 32-bit slice per cycle through a single shared adder.
module wide_add_seq #(
  parameter int unsigned WORDS = add_seq_pkg::WORDS_DEF,
  parameter int unsigned W     = add_seq_pkg::W
) (
  input  logic          clk,
  input  logic          rst_n,
  wide_add_seq_if.slave bus
);

  localparam int unsigned IdxW = add_seq_pkg::idx_width(WORDS);
  localparam int unsigned NB   = W * WORDS;

  add_seq_pkg::state_e state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic                carry_q, carry_d;
  logic [NB-1:0]       a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic                cout_q, cout_d, ovf_q, ovf_d;

  logic [W-1:0] add_a, add_b, add_s;
  logic         add_co;

  assign add_a = a_q[idx_q*W +: W];
  assign add_b = b_q[idx_q*W +: W];

  skl_32_cskip_8 u_add (
    .a    (add_a),
    .b    (add_b),
    .cin  (carry_q),
    .sum  (add_s),
    .cout (add_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    unique case (state_q)
      add_seq_pkg::StIdle: begin
        if (bus.in_valid) begin
          a_d     = bus.in_a;
          b_d     = bus.in_b ^ {NB{bus.in_sub}};
          carry_d = bus.in_sub | bus.in_cin;
          idx_d   = '0;
          state_d = add_seq_pkg::StRun;
        end
      end
      add_seq_pkg::StRun: begin
        sum_d[idx_q*W +: W] = add_s;
        carry_d             = add_co;
        idx_d               = idx_q + 1'b1;
        if (idx_q == IdxW'(WORDS - 1)) begin
          idx_d   = '0;
          cout_d  = add_co;
          // a^b^s at the MSB recovers the carry into the MSB.
          ovf_d   = add_a[W-1] ^ add_b[W-1] ^ add_s[W-1] ^ add_co;
          state_d = add_seq_pkg::StDone;
        end
      end
      add_seq_pkg::StDone: begin
        if (bus.out_ready) state_d = add_seq_pkg::StIdle;
      end
      default: state_d = add_seq_pkg::StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= add_seq_pkg::StIdle;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == add_seq_pkg::StIdle);
  assign bus.out_valid = (state_q == add_seq_pkg::StDone);
  assign bus.out_sum   = sum_q;
  assign bus.out_cout  = cout_q;
  assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: arithmetic model plus directed vectors.
module tb_wide_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned NB    = 32 * WORDS;
  localparam int          NV    = 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  wide_add_seq_if #(.WORDS(WORDS)) bus ();

  wide_add_seq #(.WORDS(WORDS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [NB-1:0] v_a [NV] = '{
    128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF,
    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
    128'h5,
    128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
    128'h8000_0000_0000_0000_0000_0000_0000_0000,
    128'hA,
    128'h3};
  logic [NB-1:0] v_b [NV] = '{
    128'h1, 128'h0, 128'h7, 128'h1,
    128'h8000_0000_0000_0000_0000_0000_0000_0000,
    128'h3, 128'h4};
  logic v_sub [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic v_cin [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [NB-1:0] e_sum [NV] = '{
    128'h0000_0000_0000_0000_0000_0001_0000_0000,
    128'h0,
    128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE,
    128'h8000_0000_0000_0000_0000_0000_0000_0000,
    128'h0,
    128'h7,
    128'h7};
  logic e_cout [NV] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic e_ovf  [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  // Result packed as {ovf, cout, sum}.
  function automatic logic [NB+1:0] model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                          input logic sub, input logic cin);
    logic [NB-1:0] bb;
    logic [NB:0]   full;
    logic          ovf;
    bb   = sub ? ~b : b;
    full = {1'b0, a} + {1'b0, bb} + {{NB{1'b0}}, (sub | cin)};
    ovf  = (a[NB-1] == bb[NB-1]) && (full[NB-1] != a[NB-1]);
    return {ovf, full};
  endfunction

  logic            m_busy, m_done;
  int              m_cnt;
  logic [NB+1:0]   m_pend, m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
      m_pend <= '0;
      m_res  <= '0;
    end else if (m_busy) begin
      if (m_cnt == WORDS - 1) begin
        m_busy <= 1'b0;
        m_done <= 1'b1;
        m_res  <= m_pend;
      end else begin
        m_cnt <= m_cnt + 1;
      end
    end else if (m_done) begin
      if (bus.out_ready) m_done <= 1'b0;
    end else if (bus.in_valid) begin
      m_busy <= 1'b1;
      m_cnt  <= 0;
      m_pend <= model(bus.in_a, bus.in_b, bus.in_sub, bus.in_cin);
    end
  end

  int n_checks = 0;
  int n_fail   = 0;
  int n_res    = 0;

  task automatic chk(input string nm, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk1("in_ready", bus.in_ready, !m_busy && !m_done);
    chk1("out_valid", bus.out_valid, m_done);
    if (!m_busy) chk("out_sum", bus.out_sum, m_res[NB-1:0]);
    if (m_done) begin
      chk1("out_cout", bus.out_cout, m_res[NB]);
      chk1("out_ovf", bus.out_ovf, m_res[NB+1]);
      if (bus.out_valid && bus.out_ready) begin
        if (n_res < NV) begin
          chk("lit_sum", bus.out_sum, e_sum[n_res]);
          chk1("lit_cout", bus.out_cout, e_cout[n_res]);
          chk1("lit_ovf", bus.out_ovf, e_ovf[n_res]);
          chk("model_vs_lit", m_res[NB-1:0], e_sum[n_res]);
        end
        n_res++;
      end
    end
  end

  task automatic send_v(input logic [NB-1:0] a, input logic [NB-1:0] b,
                        input logic sub, input logic cin);
    logic rdy, acc;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sub   = sub;
    bus.in_cin   = cin;
    bus.in_valid = 1'b1;
    acc          = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      acc = rdy;
    end
    if (!acc) begin
      $display("FAIL accept_timeout: got no accept expected accept within 40 cycles");
      $fatal(1);
    end
    bus.in_valid = 1'b0;
    bus.in_a     = {$urandom, $urandom, $urandom, $urandom};
    bus.in_b     = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic send(input int k);
    send_v(v_a[k], v_b[k], v_sub[k], v_cin[k]);
  endtask

  task automatic wait_valid();
    logic seen;
    seen = 1'b0;
    for (int t = 0; t < 40 && !seen; t++) begin
      @(posedge clk);
      #1;
      seen = bus.out_valid;
    end
    if (!seen) begin
      $display("FAIL valid_timeout: got no out_valid expected out_valid within 40 cycles");
      $fatal(1);
    end
  endtask

  task automatic collect();
    bus.out_ready = 1'b1;
    wait_valid();
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_sub    = 1'b0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      send(k);
      collect();
    end

    // Backpressure: result parked while a new request is offered.
    send(4);
    bus.out_ready = 1'b0;
    wait_valid();
    bus.in_a     = v_a[5];
    bus.in_b     = v_b[5];
    bus.in_sub   = v_sub[5];
    bus.in_cin   = v_cin[5];
    bus.in_valid = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    send(5);
    collect();

    // Abort mid-operation at slice index 2.
    send_v(128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
           128'h1111_2222_3333_4444_5555_6666_7777_8888, 1'b0, 1'b1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(6);
    collect();

    repeat (3) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
